// File: rtl/ex_divider_pkg.sv
// Shared constants and types for the EX-stage iterative divider:
// op encodings (funct3[1:0]), FSM state encoding and iteration counts.
package ex_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int ITER_D = 64;
    localparam int ITER_W = 32;
    localparam int CNT_W  = 6;

endpackage

// File: rtl/ex_divider_div_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, trial-subtract.
// Ports: rem_i/dvsr_i/bit_i in; rem_o (next partial remainder), qbit_o out.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvsr_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvsr_i};
    assign qbit_o  = ~diff[XLEN];
    assign rem_o   = qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_divider.sv
// EX-stage iterative divider (DIV/DIVU/REM/REMU and W forms) with stall.
// Ports: clock, reset (sync, high), start_i, op_i, word_i, src1_i, src2_i,
//        flush_i in; div_stall_o (to hazard control), result_o out.
// Optional: `define DIV_EARLY_OUT_EN lets trivial divides skip CALC.
module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            div_stall_o,
    output logic [XLEN-1:0] result_o
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [XLEN-1:0]  a_q;
    logic             is_rem_q;
    logic             word_q;
    logic             negq_q;
    logic             negr_q;
    logic             div0_q;
    logic             ovf_q;
    logic [XLEN-1:0]  result_q;

    // Operand preparation from the live inputs (used on acceptance).
    logic            is_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] min_val;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] dvd_init;

    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] dvd_d;
    logic [XLEN-1:0] result_d;

    function automatic logic [XLEN-1:0] fix_result(
        input logic            is_rem,
        input logic            word,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            nq,
        input logic            nr,
        input logic            d0,
        input logic            ov,
        input logic [XLEN-1:0] a
    );
        logic [XLEN-1:0] v;
        if (d0) begin
            v = is_rem ? a : '1;
        end else if (ov) begin
            v = is_rem ? '0 : a;
        end else if (is_rem) begin
            v = nr ? -r : r;
        end else begin
            v = nq ? -q : q;
        end
        // W results are always sign-extended from bit 31.
        if (word) begin
            v = {{(XLEN-32){v[31]}}, v[31:0]};
        end
        return v;
    endfunction

    always_comb begin
        is_signed = ~op_i[0];
        a_ext = src1_i;
        b_ext = src2_i;
        if (word_i) begin
            a_ext = {{(XLEN-32){is_signed & src1_i[31]}}, src1_i[31:0]};
            b_ext = {{(XLEN-32){is_signed & src2_i[31]}}, src2_i[31:0]};
        end
        a_neg = is_signed & a_ext[XLEN-1];
        b_neg = is_signed & b_ext[XLEN-1];
        abs_a = a_neg ? -a_ext : a_ext;
        abs_b = b_neg ? -b_ext : b_ext;
        if (word_i) begin
            min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        div0 = (b_ext == '0);
        ovf  = is_signed & (a_ext == min_val) & (b_ext == '1);
        // W ops start iterating from bit 31, so park it at the MSB.
        if (word_i) begin
            dvd_init = {abs_a[31:0], {(XLEN-32){1'b0}}};
        end else begin
            dvd_init = abs_a;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i  (rem_q),
        .dvsr_i (dvsr_q),
        .bit_i  (dvd_q[XLEN-1]),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    // Dividend bits leave at the top while quotient bits enter below.
    assign dvd_d = {dvd_q[XLEN-2:0], step_q};

    always_comb begin
        result_d = fix_result(is_rem_q, word_q, dvd_d, step_rem,
                              negq_q, negr_q, div0_q, ovf_q, a_q);
    end

`ifdef DIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] result_early_d;

    always_comb begin
        early = div0 | ovf | (abs_a < abs_b);
        // Small-dividend case: quotient 0, remainder is the dividend.
        result_early_d = fix_result(op_i[1], word_i, '0, abs_a,
                                    is_signed & (a_neg ^ b_neg),
                                    a_neg, div0, ovf, a_ext);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvsr_q   <= '0;
            a_q      <= '0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        rem_q    <= '0;
                        dvd_q    <= dvd_init;
                        dvsr_q   <= abs_b;
                        a_q      <= a_ext;
                        is_rem_q <= op_i[1];
                        word_q   <= word_i;
                        negq_q   <= is_signed & (a_neg ^ b_neg);
                        negr_q   <= a_neg;
                        div0_q   <= div0;
                        ovf_q    <= ovf;
                        cnt_q    <= word_i ? CNT_W'(ITER_W - 1)
                                           : CNT_W'(ITER_D - 1);
`ifdef DIV_EARLY_OUT_EN
                        if (early) begin
                            result_q <= result_early_d;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= step_rem;
                        dvd_q <= dvd_d;
                        if (cnt_q == '0) begin
                            result_q <= result_d;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_stall_o = start_i & ~flush_i & ~reset
                       & (state_q != S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider.
module tb_ex_divider;
    import ex_divider_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int ES  = 1;
    localparam int ESW = 1;
`else
    localparam int ES  = 65;
    localparam int ESW = 33;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic        word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        div_stall_o;
    logic [63:0] result_o;

    int vectors     = 0;
    int miscompares = 0;

    ex_divider #(.XLEN(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .op_i        (op_i),
        .word_i      (word_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .flush_i     (flush_i),
        .div_stall_o (div_stall_o),
        .result_o    (result_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        op_i    = op;
        word_i  = w;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
    endtask

    // Counts stall cycles up to the result cycle, then checks both.
    task automatic finish_op(input string tag, input logic [63:0] exp,
                             input int exp_n);
        int n = 0;
        while (div_stall_o === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk({tag, " stalls"}, 64'(n), 64'(exp_n));
        chk({tag, " result"}, result_o, exp);
        start_i = 1'b0;
        tick();
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int exp_n);
        drive(op, w, a, b);
        #1;
        finish_op(tag, exp, exp_n);
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b1;
        flush_i = 1'b0;
        op_i    = OP_DIVU;
        word_i  = 1'b0;
        src1_i  = 64'd100;
        src2_i  = 64'd7;
        tick();
        tick();
        chk("reset stall", 64'(div_stall_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        start_i = 1'b0;
        reset   = 1'b0;
        tick();

        run("divu 100/7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run("remu 100/7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run("div -7/2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem -7/2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("remw -7%2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("div 5/0", OP_DIV, 1'b0, 64'd5, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, ES);
        run("rem 5/0", OP_REM, 1'b0, 64'd5, 64'd0, 64'd5, ES);
        run("div ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, ES);
        run("rem ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, ES);
        run("divuw", OP_DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
            64'hFFFF_FFFF_8000_0000, 33);
        run("divw", OP_DIV, 1'b1, 64'h0000_0001_0000_0010, 64'd4,
            64'd4, 33);
        run("divw ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000,
            64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, ESW);
        run("remu 3/10", OP_REMU, 1'b0, 64'd3, 64'd10, 64'd3, ES);
        run("remuw 7/0", OP_REMU, 1'b1, 64'h1234_5678_F000_0007,
            64'h5_0000_0000, 64'hFFFF_FFFF_F000_0007, ESW);

        // Flush in CALC cycle 10; the new op must see a fresh IDLE.
        drive(OP_DIVU, 1'b0, 64'd1000, 64'd7);
        repeat (10) tick();
        flush_i = 1'b1;
        #1;
        chk("flush stall", 64'(div_stall_o), 64'd0);
        tick();
        flush_i = 1'b0;
        drive(OP_DIVU, 1'b0, 64'd10, 64'd3);
        #1;
        finish_op("divu after flush", 64'd3, 65);

        // Reset in the middle of CALC.
        drive(OP_DIV, 1'b0, 64'd100, 64'd7);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("mid reset stall", 64'(div_stall_o), 64'd0);
        tick();
        chk("mid reset result", result_o, 64'd0);
        chk("mid reset stall2", 64'(div_stall_o), 64'd0);
        start_i = 1'b0;
        reset   = 1'b0;
        tick();
        run("div 9/3", OP_DIV, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
